loaded_word_monitor: RTL and testbench
======================================

# loaded_word_monitor

- Sits directly downstream of the 16-flop `DFF_X1` bank whose D pins share one high-fanout net; consumes the bank's 16-bit output word.
- Checks each sampled word for uniformity: every bit driven from one net must agree.
- Counts level edges and non-uniform words (skew/fault events) and tracks state in a 3-state FSM.
- Exposes counter snapshots through a req/valid/ack handshake for the buffering-evaluation testbench.

## Interface
Parameters:
- `WIDTH`, 16, width of monitored word (≥2)
- `CNT_W`, 8, width of edge and error counters

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_word`  in  WIDTH  word from the register bank (`out[15:0]`)
- `in_valid`  in  1  `in_word` is meaningful this cycle
- `clr_fault`  in  1  leave FAULT, return to IDLE
- `snap_req`  in  1  request counter snapshot
- `snap_ack`  in  1  consumer accepts snapshot
- `state_o`  out  2  FSM state: IDLE=0, TRACK=1, FAULT=2
- `level_o`  out  1  last accepted uniform level
- `edge_cnt_o`  out  CNT_W  live edge count
- `err_cnt_o`  out  CNT_W  live non-uniform word count
- `snap_valid`  out  1  snapshot registers hold data
- `snap_edges`  out  CNT_W  captured edge count
- `snap_errs`  out  CNT_W  captured error count

## Operation
- uniform = `in_word` all 0s or all 1s; value = `in_word[0]`.
- Edge event: `in_valid` & uniform & `have_ref` & value≠`level_o`.
  - Any valid uniform word loads `level_o`<=value and `have_ref`<=1.
- Error event: `in_valid` & !uniform. `level_o` and `have_ref` are unchanged.
- `in_valid`=0: no event, no state change.
- Counters saturate at 2^CNT_W−1; they never wrap.
- FSM:
  - IDLE→TRACK on first valid uniform word.
  - IDLE/TRACK→FAULT on an error event.
  - FAULT→IDLE on `clr_fault`; this also clears `have_ref`.
  - `clr_fault` in IDLE/TRACK has no effect.
  - `clr_fault` plus error event in the same cycle: stay in FAULT; error is counted.
  - In FAULT, uniform words still update `level_o` and edge counting.
- Snapshot:
  - `snap_req` is accepted only while `snap_valid`=0.
  - On accept, the snapshot captures the live counters including any event in the request cycle (saturated). Live counters load 0 that cycle.
  - `snap_ack` is honoured only while `snap_valid`=1; it clears `snap_valid`. Snapshot data holds until the next capture.
  - `snap_req` while `snap_valid`=1 is ignored, even if `snap_ack` is in the same cycle. The requester must re-assert.
- Reset values: all outputs 0, `state_o`=IDLE, `have_ref`=0.

## Timing
- All outputs registered.
- An event sampled at edge N is visible on the outputs after edge N (1-cycle latency).
- `snap_valid` rises one cycle after an accepted `snap_req`; it falls one cycle after `snap_ack`.
- `rst` asserted mid-operation clears everything on the next edge, including a pending snapshot. Inputs in that cycle are ignored.
- No combinational input→output path.

## Test plan
- Reset, then valid words 0x0000, 0xFFFF, 0xFFFF, 0x0000 → `state_o`=1, `edge_cnt_o`=2, `level_o`=0, `err_cnt_o`=0.
- Valid 0xFFFF then 0xFFFE → `state_o`=2, `err_cnt_o`=1, `level_o`=1 unchanged. Then `clr_fault` with 0x0001 in the same cycle → remains 2, `err_cnt_o`=2. Then `clr_fault` alone → IDLE.
- 300 alternating 0x0000/0xFFFF valid words with CNT_W=8 → `edge_cnt_o` holds at 255.
- Live edges=5; `snap_req` in a cycle that carries a sixth edge → next cycle `snap_valid`=1, `snap_edges`=6, `edge_cnt_o`=0. A second `snap_req` is ignored. `snap_ack` → `snap_valid`=0 next cycle.
- Garbage words with `in_valid`=0 → no count change, state unchanged.
- `rst` pulsed with `snap_valid`=1 and state FAULT → all outputs 0 next cycle.

Source files
------------

// File: rtl/loaded_word_monitor.sv
// Uniformity monitor for a 16-flop bank fed from one high-fanout net.
// Counts level edges and non-uniform words, tracks IDLE/TRACK/FAULT, and exposes counter snapshots.
module loaded_word_monitor #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_word,
    input  logic             in_valid,
    input  logic             clr_fault,
    input  logic             snap_req,
    input  logic             snap_ack,
    output logic [1:0]       state_o,
    output logic             level_o,
    output logic [CNT_W-1:0] edge_cnt_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic             snap_valid,
    output logic [CNT_W-1:0] snap_edges,
    output logic [CNT_W-1:0] snap_errs
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           r_state;
    logic             r_level;
    logic             r_have_ref;
    logic [CNT_W-1:0] r_edge_cnt;
    logic [CNT_W-1:0] r_err_cnt;
    logic             r_snap_valid;
    logic [CNT_W-1:0] r_snap_edges;
    logic [CNT_W-1:0] r_snap_errs;

    logic             w_uniform;
    logic             w_valid_uni;
    logic             w_edge_ev;
    logic             w_err_ev;
    logic             w_snap_take;
    logic [CNT_W-1:0] w_edge_next;
    logic [CNT_W-1:0] w_err_next;

    assign w_uniform   = (&in_word) | ~(|in_word);
    assign w_valid_uni = in_valid & w_uniform;
    assign w_edge_ev   = w_valid_uni & r_have_ref & (in_word[0] != r_level);
    assign w_err_ev    = in_valid & ~w_uniform;
    assign w_snap_take = snap_req & ~r_snap_valid;

    // Counters stick at all-ones rather than wrapping.
    assign w_edge_next = (w_edge_ev && r_edge_cnt != CNT_MAX) ? r_edge_cnt + CNT_W'(1) : r_edge_cnt;
    assign w_err_next  = (w_err_ev && r_err_cnt != CNT_MAX) ? r_err_cnt + CNT_W'(1) : r_err_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_level      <= 1'b0;
            r_have_ref   <= 1'b0;
            r_edge_cnt   <= '0;
            r_err_cnt    <= '0;
            r_snap_valid <= 1'b0;
            r_snap_edges <= '0;
            r_snap_errs  <= '0;
        end else begin
            if (w_valid_uni) begin
                r_level    <= in_word[0];
                r_have_ref <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_err_ev)         r_state <= ST_FAULT;
                    else if (w_valid_uni) r_state <= ST_TRACK;
                end
                ST_TRACK: begin
                    if (w_err_ev) r_state <= ST_FAULT;
                end
                ST_FAULT: begin
                    // Clearing drops the reference even if a uniform word arrives alongside.
                    if (clr_fault && !w_err_ev) begin
                        r_state    <= ST_IDLE;
                        r_have_ref <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            if (w_snap_take) begin
                r_snap_valid <= 1'b1;
                r_snap_edges <= w_edge_next;
                r_snap_errs  <= w_err_next;
                r_edge_cnt   <= '0;
                r_err_cnt    <= '0;
            end else begin
                r_edge_cnt <= w_edge_next;
                r_err_cnt  <= w_err_next;
                if (snap_ack && r_snap_valid) r_snap_valid <= 1'b0;
            end
        end
    end

    assign state_o    = r_state;
    assign level_o    = r_level;
    assign edge_cnt_o = r_edge_cnt;
    assign err_cnt_o  = r_err_cnt;
    assign snap_valid = r_snap_valid;
    assign snap_edges = r_snap_edges;
    assign snap_errs  = r_snap_errs;

endmodule

// File: tb/tb_loaded_word_monitor.sv
// Bench for loaded_word_monitor: directed scenarios plus randomized traffic
// checked against an event-level reference model.
module tb_loaded_word_monitor;

    localparam int WIDTH = 16;
    localparam int CNT_W = 8;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] in_word;
    logic             in_valid;
    logic             clr_fault;
    logic             snap_req;
    logic             snap_ack;
    logic [1:0]       state_o;
    logic             level_o;
    logic [CNT_W-1:0] edge_cnt_o;
    logic [CNT_W-1:0] err_cnt_o;
    logic             snap_valid;
    logic [CNT_W-1:0] snap_edges;
    logic [CNT_W-1:0] snap_errs;

    int checks   = 0;
    int failures = 0;

    // reference model state
    int m_state;
    bit m_level;
    bit m_have_ref;
    int m_edges;
    int m_errs;
    bit m_snap_valid;
    int m_snap_edges;
    int m_snap_errs;

    always #5 clk = ~clk;

    loaded_word_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_word    (in_word),
        .in_valid   (in_valid),
        .clr_fault  (clr_fault),
        .snap_req   (snap_req),
        .snap_ack   (snap_ack),
        .state_o    (state_o),
        .level_o    (level_o),
        .edge_cnt_o (edge_cnt_o),
        .err_cnt_o  (err_cnt_o),
        .snap_valid (snap_valid),
        .snap_edges (snap_edges),
        .snap_errs  (snap_errs)
    );

    task automatic model_step(input bit r, input bit v, input logic [WIDTH-1:0] w,
                              input bit c, input bit q, input bit a);
        bit uni, ev_edge, ev_err;
        int old_state, e, x;
        if (r) begin
            m_state = 0; m_level = 0; m_have_ref = 0; m_edges = 0; m_errs = 0;
            m_snap_valid = 0; m_snap_edges = 0; m_snap_errs = 0;
            return;
        end
        uni       = (w == '0) || (w == '1);
        ev_edge   = v && uni && m_have_ref && (w[0] != m_level);
        ev_err    = v && !uni;
        old_state = m_state;
        e = m_edges + (ev_edge ? 1 : 0); if (e > MAXC) e = MAXC;
        x = m_errs + (ev_err ? 1 : 0);   if (x > MAXC) x = MAXC;
        if (q && !m_snap_valid) begin
            m_snap_valid = 1; m_snap_edges = e; m_snap_errs = x; e = 0; x = 0;
        end else if (a && m_snap_valid) begin
            m_snap_valid = 0;
        end
        m_edges = e;
        m_errs  = x;
        if (v && uni) begin
            m_level = w[0];
            m_have_ref = 1;
        end
        if (ev_err) m_state = 2;
        else if (old_state == 0 && v && uni) m_state = 1;
        else if (old_state == 2 && c) begin
            m_state = 0;
            m_have_ref = 0;
        end
    endtask

    task automatic cycle(input bit r, input bit v, input logic [WIDTH-1:0] w,
                         input bit c, input bit q, input bit a);
        rst = r; in_valid = v; in_word = w; clr_fault = c; snap_req = q; snap_ack = a;
        @(posedge clk);
        #1;
        model_step(r, v, w, c, q, a);
        rst = 0; in_valid = 0; clr_fault = 0; snap_req = 0; snap_ack = 0;
    endtask

    task automatic test_reset();
        cycle(1, 1, 16'h1234, 1, 1, 1);
        checks++;
        if (state_o !== 2'd0 || level_o !== 1'b0 || edge_cnt_o !== '0 || err_cnt_o !== '0 ||
            snap_valid !== 1'b0 || snap_edges !== '0 || snap_errs !== '0) begin
            failures++;
            $display("FAIL reset_state: got st=%0d lvl=%0b e=%0d r=%0d sv=%0b se=%0d sr=%0d, want all 0",
                     state_o, level_o, edge_cnt_o, err_cnt_o, snap_valid, snap_edges, snap_errs);
        end
    endtask

    task automatic test_edges();
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 1, 16'h0000, 0, 0, 0);
        checks++;
        if (state_o !== 2'd1) begin failures++; $display("FAIL idle_to_track: got %0d want 1", state_o); end
        cycle(0, 1, 16'hFFFF, 0, 0, 0);
        cycle(0, 1, 16'hFFFF, 0, 0, 0);
        cycle(0, 1, 16'h0000, 0, 0, 0);
        checks++;
        if (state_o !== 2'd1 || edge_cnt_o !== 8'd2 || level_o !== 1'b0 || err_cnt_o !== 8'd0) begin
            failures++;
            $display("FAIL edge_count: got st=%0d e=%0d lvl=%0b r=%0d want st=1 e=2 lvl=0 r=0",
                     state_o, edge_cnt_o, level_o, err_cnt_o);
        end
    endtask

    task automatic test_fault();
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 1, 16'hFFFF, 0, 0, 0);
        cycle(0, 1, 16'hFFFE, 0, 0, 0);
        checks++;
        if (state_o !== 2'd2 || err_cnt_o !== 8'd1 || level_o !== 1'b1) begin
            failures++;
            $display("FAIL fault_entry: got st=%0d r=%0d lvl=%0b want st=2 r=1 lvl=1", state_o, err_cnt_o, level_o);
        end
        cycle(0, 1, 16'h0001, 1, 0, 0);
        checks++;
        if (state_o !== 2'd2 || err_cnt_o !== 8'd2) begin
            failures++;
            $display("FAIL clr_with_error: got st=%0d r=%0d want st=2 r=2", state_o, err_cnt_o);
        end
        cycle(0, 0, 16'h0000, 1, 0, 0);
        checks++;
        if (state_o !== 2'd0) begin failures++; $display("FAIL clr_fault: got st=%0d want 0", state_o); end
        cycle(0, 1, 16'h0000, 0, 0, 0);
        checks++;
        if (state_o !== 2'd1 || edge_cnt_o !== 8'd0 || level_o !== 1'b0) begin
            failures++;
            $display("FAIL after_clr_no_edge: got st=%0d e=%0d lvl=%0b want st=1 e=0 lvl=0", state_o, edge_cnt_o, level_o);
        end
        cycle(0, 0, 16'h0000, 1, 0, 0);
        checks++;
        if (state_o !== 2'd1) begin failures++; $display("FAIL clr_in_track: got st=%0d want 1", state_o); end
    endtask

    task automatic test_saturation();
        cycle(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 300; i++) begin
            cycle(0, 1, (i % 2 == 0) ? 16'h0000 : 16'hFFFF, 0, 0, 0);
            if (i == 255) begin
                checks++;
                if (edge_cnt_o !== 8'd255) begin
                    failures++; $display("FAIL sat_reach: got %0d want 255", edge_cnt_o);
                end
            end
        end
        checks++;
        if (edge_cnt_o !== 8'd255) begin failures++; $display("FAIL sat_hold: got %0d want 255", edge_cnt_o); end
    endtask

    task automatic test_snapshot();
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 1, 16'h0000, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 1, (i % 2 == 0) ? 16'hFFFF : 16'h0000, 0, 0, 0);
        checks++;
        if (edge_cnt_o !== 8'd5) begin failures++; $display("FAIL snap_pre: got %0d want 5", edge_cnt_o); end
        cycle(0, 1, 16'h0000, 0, 1, 0);
        checks++;
        if (snap_valid !== 1'b1 || snap_edges !== 8'd6 || edge_cnt_o !== 8'd0 || snap_errs !== 8'd0) begin
            failures++;
            $display("FAIL snap_capture: got sv=%0b se=%0d e=%0d sr=%0d want sv=1 se=6 e=0 sr=0",
                     snap_valid, snap_edges, edge_cnt_o, snap_errs);
        end
        cycle(0, 1, 16'hFFFF, 0, 1, 0);
        checks++;
        if (snap_valid !== 1'b1 || snap_edges !== 8'd6 || edge_cnt_o !== 8'd1) begin
            failures++;
            $display("FAIL snap_req_ignored: got sv=%0b se=%0d e=%0d want sv=1 se=6 e=1", snap_valid, snap_edges, edge_cnt_o);
        end
        cycle(0, 0, 16'h0000, 0, 0, 1);
        checks++;
        if (snap_valid !== 1'b0 || snap_edges !== 8'd6) begin
            failures++;
            $display("FAIL snap_ack: got sv=%0b se=%0d want sv=0 se=6", snap_valid, snap_edges);
        end
        cycle(0, 1, 16'h0000, 0, 1, 0);
        checks++;
        if (snap_valid !== 1'b1 || snap_edges !== 8'd2) begin
            failures++;
            $display("FAIL snap_recapture: got sv=%0b se=%0d want sv=1 se=2", snap_valid, snap_edges);
        end
        cycle(0, 0, 16'h0000, 0, 1, 1);
        checks++;
        if (snap_valid !== 1'b0 || snap_edges !== 8'd2) begin
            failures++;
            $display("FAIL snap_req_with_ack: got sv=%0b se=%0d want sv=0 se=2", snap_valid, snap_edges);
        end
    endtask

    task automatic test_invalid();
        logic [1:0] st0; logic [CNT_W-1:0] e0, r0; logic l0;
        cycle(0, 1, 16'hFFFF, 0, 0, 0);
        st0 = state_o; e0 = edge_cnt_o; r0 = err_cnt_o; l0 = level_o;
        for (int i = 0; i < 10; i++) cycle(0, 0, 16'(($urandom % 65534) + 1), 0, 0, 0);
        checks++;
        if (state_o !== 2'd1 || edge_cnt_o !== 8'd1 || err_cnt_o !== 8'd0 || level_o !== 1'b1 ||
            state_o !== st0 || edge_cnt_o !== e0 || err_cnt_o !== r0 || level_o !== l0) begin
            failures++;
            $display("FAIL invalid_words: got st=%0d e=%0d r=%0d lvl=%0b want st=1 e=1 r=0 lvl=1",
                     state_o, edge_cnt_o, err_cnt_o, level_o);
        end
    endtask

    task automatic test_reset_mid();
        cycle(0, 1, 16'h00F0, 0, 1, 0);
        checks++;
        if (state_o !== 2'd2 || snap_valid !== 1'b1) begin
            failures++; $display("FAIL rst_setup: got st=%0d sv=%0b want st=2 sv=1", state_o, snap_valid);
        end
        cycle(1, 1, 16'h0F00, 1, 1, 0);
        checks++;
        if (state_o !== 2'd0 || level_o !== 1'b0 || edge_cnt_o !== '0 || err_cnt_o !== '0 ||
            snap_valid !== 1'b0 || snap_edges !== '0 || snap_errs !== '0) begin
            failures++;
            $display("FAIL rst_mid: got st=%0d lvl=%0b e=%0d r=%0d sv=%0b se=%0d sr=%0d want all 0",
                     state_o, level_o, edge_cnt_o, err_cnt_o, snap_valid, snap_edges, snap_errs);
        end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] w;
        int sel;
        for (int i = 0; i < 1500; i++) begin
            sel = $urandom_range(0, 9);
            if (sel < 4)      w = '0;
            else if (sel < 8) w = '1;
            else              w = WIDTH'($urandom);
            cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), w,
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0), ($urandom_range(0, 4) == 0));
            checks++;
            if (state_o !== 2'(m_state) || level_o !== m_level || edge_cnt_o !== CNT_W'(m_edges) ||
                err_cnt_o !== CNT_W'(m_errs) || snap_valid !== m_snap_valid ||
                snap_edges !== CNT_W'(m_snap_edges) || snap_errs !== CNT_W'(m_snap_errs)) begin
                failures++;
                $display("FAIL random_cycle_%0d: got st=%0d lvl=%0b e=%0d r=%0d sv=%0b se=%0d sr=%0d want st=%0d lvl=%0b e=%0d r=%0d sv=%0b se=%0d sr=%0d",
                         i, state_o, level_o, edge_cnt_o, err_cnt_o, snap_valid, snap_edges, snap_errs,
                         m_state, m_level, m_edges, m_errs, m_snap_valid, m_snap_edges, m_snap_errs);
            end
        end
    endtask

    initial begin
        rst = 1; in_word = '0; in_valid = 0; clr_fault = 0; snap_req = 0; snap_ack = 0;
        test_reset();
        test_edges();
        test_fault();
        test_saturation();
        test_snapshot();
        test_invalid();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
